// File: rtl/mem_port_arbiter.sv
`default_nettype none
// mem_port_arbiter: shares one single-ported memory between the fetch port and the data port.
// One transaction in flight; data wins arbitration unless fetch has been starved STARVE_LIMIT times.
module mem_port_arbiter #(
  parameter int WORD_SIZE    = 16,
  parameter int STARVE_LIMIT = 4,
  parameter int RD_TIMEOUT   = 64
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 InstrRead,
  input  logic [WORD_SIZE-1:0] InstrAddr,
  output logic [WORD_SIZE-1:0] InstrIn,
  output logic                 InstrWaitreq,
  input  logic                 ReadData,
  input  logic                 WriteData,
  input  logic [WORD_SIZE-1:0] DataAddr,
  input  logic [WORD_SIZE-1:0] DataOut,
  output logic [WORD_SIZE-1:0] DataIn,
  output logic                 DataWaitreq,
  output logic                 MemRead,
  output logic                 MemWrite,
  output logic [WORD_SIZE-1:0] MemAddr,
  output logic [WORD_SIZE-1:0] MemWdata,
  input  logic                 MemWaitreq,
  input  logic [WORD_SIZE-1:0] MemRdata,
  input  logic                 MemRdvalid,
  output logic                 BusErr
);

  localparam int SC_W = $clog2(STARVE_LIMIT + 1);
  localparam int TO_W = $clog2(RD_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2
  } state_t;

  state_t          state;
  logic            grant_instr;
  logic            grant_write;
  logic [SC_W-1:0] starve_cnt;
  logic [TO_W-1:0] to_cnt;

  logic data_req;
  logic pick_instr;
  logic rd_timeout;
  logic write_done;
  logic read_done;
  logic completing;
  logic rd_deliver;

  assign data_req   = ReadData | WriteData;
  assign pick_instr = InstrRead & (~data_req | (starve_cnt == SC_W'(STARVE_LIMIT)));
  assign rd_timeout = (to_cnt == TO_W'(RD_TIMEOUT - 1));
  assign write_done = (state == ISSUE) & ~MemWaitreq & grant_write;
  assign read_done  = (state == WAIT_RD) & (MemRdvalid | rd_timeout);
  // A reset cycle abandons whatever is in flight, so nothing completes while Reset is high.
  assign completing = ~Reset & (write_done | read_done);
  assign rd_deliver = completing & (state == WAIT_RD) & MemRdvalid;

  assign InstrWaitreq = Reset | (InstrRead & ~(grant_instr & completing));
  assign DataWaitreq  = Reset | (data_req & ~(~grant_instr & completing));
  assign InstrIn      = (rd_deliver & grant_instr)  ? MemRdata : '0;
  assign DataIn       = (rd_deliver & ~grant_instr) ? MemRdata : '0;

  assign BusErr = ~Reset & (((state == IDLE) & ~pick_instr & ReadData & WriteData) |
                            ((state == WAIT_RD) & ~MemRdvalid & rd_timeout));

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state       <= IDLE;
      grant_instr <= 1'b0;
      grant_write <= 1'b0;
      starve_cnt  <= '0;
      to_cnt      <= '0;
      MemRead     <= 1'b0;
      MemWrite    <= 1'b0;
      MemAddr     <= '0;
      MemWdata    <= '0;
    end else begin
      // Starvation count only matters while fetch is actually waiting.
      if (!InstrRead)
        starve_cnt <= '0;
      else if (state == IDLE && pick_instr)
        starve_cnt <= '0;
      else if (state == IDLE && data_req && starve_cnt != SC_W'(STARVE_LIMIT))
        starve_cnt <= starve_cnt + 1'b1;

      case (state)
        IDLE: begin
          to_cnt <= '0;
          if (pick_instr || data_req) begin
            grant_instr <= pick_instr;
            grant_write <= ~pick_instr & WriteData;
            MemRead     <= pick_instr | ~WriteData;
            MemWrite    <= ~pick_instr & WriteData;
            MemAddr     <= pick_instr ? InstrAddr : DataAddr;
            MemWdata    <= pick_instr ? '0 : DataOut;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          if (!MemWaitreq) begin
            MemRead  <= 1'b0;
            MemWrite <= 1'b0;
            state    <= grant_write ? IDLE : WAIT_RD;
          end
        end
        WAIT_RD: begin
          if (MemRdvalid || rd_timeout)
            state <= IDLE;
          else
            to_cnt <= to_cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// tb_mem_port_arbiter: directed cycle-by-cycle checks of the memory port arbiter.
module tb_mem_port_arbiter;

  logic        Clock;
  logic        Reset;
  logic        InstrRead;
  logic [15:0] InstrAddr;
  logic [15:0] InstrIn;
  logic        InstrWaitreq;
  logic        ReadData;
  logic        WriteData;
  logic [15:0] DataAddr;
  logic [15:0] DataOut;
  logic [15:0] DataIn;
  logic        DataWaitreq;
  logic        MemRead;
  logic        MemWrite;
  logic [15:0] MemAddr;
  logic [15:0] MemWdata;
  logic        MemWaitreq;
  logic [15:0] MemRdata;
  logic        MemRdvalid;
  logic        BusErr;

  int   checks = 0;
  int   errors = 0;
  logic expv;

  mem_port_arbiter #(.WORD_SIZE(16), .STARVE_LIMIT(4), .RD_TIMEOUT(64)) dut (
    .Clock(Clock), .Reset(Reset),
    .InstrRead(InstrRead), .InstrAddr(InstrAddr), .InstrIn(InstrIn), .InstrWaitreq(InstrWaitreq),
    .ReadData(ReadData), .WriteData(WriteData), .DataAddr(DataAddr), .DataOut(DataOut),
    .DataIn(DataIn), .DataWaitreq(DataWaitreq),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemAddr(MemAddr), .MemWdata(MemWdata),
    .MemWaitreq(MemWaitreq), .MemRdata(MemRdata), .MemRdvalid(MemRdvalid), .BusErr(BusErr)
  );

  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] req);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, req);
    end
  endtask

  task automatic quiet();
    InstrRead = 0; ReadData = 0; WriteData = 0;
    MemWaitreq = 0; MemRdvalid = 0; MemRdata = '0;
  endtask

  initial begin
    Clock = 0; Reset = 1;
    InstrAddr = '0; DataAddr = '0; DataOut = '0;
    quiet();
    tick(); tick();
    chk("rst_iwait", InstrWaitreq, 1);
    chk("rst_dwait", DataWaitreq, 1);
    chk("rst_memread", MemRead, 0);
    chk("rst_memwrite", MemWrite, 0);
    chk("rst_memaddr", MemAddr, 16'h0000);
    chk("rst_buserr", BusErr, 0);
    Reset = 0;
    tick();

    // T1: data read, immediate accept, rdvalid one cycle later
    ReadData = 1; DataAddr = 16'h0100; #1;
    chk("t1_c1_dwait", DataWaitreq, 1);
    chk("t1_c1_memread", MemRead, 0);
    tick(); #1;
    chk("t1_c2_memread", MemRead, 1);
    chk("t1_c2_memaddr", MemAddr, 16'h0100);
    chk("t1_c2_dwait", DataWaitreq, 1);
    tick();
    MemRdvalid = 1; MemRdata = 16'hBEEF; #1;
    chk("t1_c3_datain", DataIn, 16'hBEEF);
    chk("t1_c3_dwait", DataWaitreq, 0);
    chk("t1_c3_memread", MemRead, 0);
    tick();
    quiet(); #1;
    chk("t1_idle_datain", DataIn, 16'h0000);
    tick();

    // T2: write held off by MemWaitreq for two cycles
    WriteData = 1; DataAddr = 16'h0010; DataOut = 16'h1234; MemWaitreq = 1;
    tick();
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("t2_hold_memwrite", MemWrite, 1);
      chk("t2_hold_memaddr", MemAddr, 16'h0010);
      chk("t2_hold_memwdata", MemWdata, 16'h1234);
      chk("t2_hold_dwait", DataWaitreq, 1);
      tick();
    end
    MemWaitreq = 0; #1;
    chk("t2_acc_memwrite", MemWrite, 1);
    chk("t2_acc_memwdata", MemWdata, 16'h1234);
    chk("t2_acc_dwait", DataWaitreq, 0);
    tick();
    quiet(); #1;
    chk("t2_after_memwrite", MemWrite, 0);
    tick();

    // T3: instr and data requested together; data first
    InstrRead = 1; InstrAddr = 16'h0200; ReadData = 1; DataAddr = 16'h0300; #1;
    chk("t3_c1_iwait", InstrWaitreq, 1);
    chk("t3_c1_dwait", DataWaitreq, 1);
    tick(); #1;
    chk("t3_c2_memaddr", MemAddr, 16'h0300);
    tick();
    MemRdvalid = 1; MemRdata = 16'h1111; #1;
    chk("t3_c3_datain", DataIn, 16'h1111);
    chk("t3_c3_dwait", DataWaitreq, 0);
    chk("t3_c3_iwait", InstrWaitreq, 1);
    chk("t3_c3_instrin", InstrIn, 16'h0000);
    tick();
    ReadData = 0; MemRdvalid = 0; #1;
    chk("t3_c4_iwait", InstrWaitreq, 1);
    tick(); #1;
    chk("t3_c5_memaddr", MemAddr, 16'h0200);
    chk("t3_c5_memread", MemRead, 1);
    tick(); #1;
    chk("t3_c6_iwait", InstrWaitreq, 1);
    tick();
    MemRdvalid = 1; MemRdata = 16'h2222; #1;
    chk("t3_c7_instrin", InstrIn, 16'h2222);
    chk("t3_c7_iwait", InstrWaitreq, 0);
    chk("t3_c7_datain", DataIn, 16'h0000);
    tick();
    quiet();
    tick();

    // T4: starvation guard, fifth grant goes to instr
    InstrRead = 1; InstrAddr = 16'h0400; ReadData = 1; DataAddr = 16'h0500;
    for (int k = 0; k < 6; k++) begin
      expv = (k == 4);
      MemWaitreq = 0; MemRdvalid = 0; #1;
      chk("t4_idle_iwait", InstrWaitreq, 1);
      tick(); #1;
      chk("t4_grant_addr", MemAddr, expv ? 16'h0400 : 16'h0500);
      tick();
      MemRdvalid = 1; MemRdata = 16'(16'hA000 + k); #1;
      if (expv) begin
        chk("t4_instrin", InstrIn, 16'(16'hA000 + k));
        chk("t4_iwait_low", InstrWaitreq, 0);
        chk("t4_dwait_high", DataWaitreq, 1);
      end else begin
        chk("t4_datain", DataIn, 16'(16'hA000 + k));
        chk("t4_dwait_low", DataWaitreq, 0);
        chk("t4_iwait_high", InstrWaitreq, 1);
      end
      tick();
    end
    quiet();
    tick();

    // T5: read timeout after 64 WAIT_RD cycles
    ReadData = 1; DataAddr = 16'h0600;
    tick(); tick();
    for (int i = 1; i < 64; i++) begin
      #1;
      chk("t5_wait_dwait", DataWaitreq, 1);
      chk("t5_wait_buserr", BusErr, 0);
      tick();
    end
    #1;
    chk("t5_to_dwait", DataWaitreq, 0);
    chk("t5_to_datain", DataIn, 16'h0000);
    chk("t5_to_buserr", BusErr, 1);
    tick();
    ReadData = 0; MemRdvalid = 1; MemRdata = 16'hDEAD; #1;
    chk("t5_late_buserr", BusErr, 0);
    chk("t5_late_datain", DataIn, 16'h0000);
    chk("t5_late_memread", MemRead, 0);
    tick();
    quiet();
    tick();

    // Read and write together: handled as a write, BusErr in the grant cycle
    ReadData = 1; WriteData = 1; DataAddr = 16'h0700; DataOut = 16'h5555; #1;
    chk("rw_grant_buserr", BusErr, 1);
    tick(); #1;
    chk("rw_memwrite", MemWrite, 1);
    chk("rw_memread", MemRead, 0);
    chk("rw_issue_buserr", BusErr, 0);
    chk("rw_dwait", DataWaitreq, 0);
    tick();
    quiet();
    tick();

    // T6: reset while in WAIT_RD, then a stray rdvalid
    ReadData = 1; DataAddr = 16'h0800;
    tick(); tick();
    Reset = 1; #1;
    chk("t6_rst_dwait", DataWaitreq, 1);
    chk("t6_rst_datain", DataIn, 16'h0000);
    tick();
    Reset = 0; ReadData = 0; MemRdvalid = 1; MemRdata = 16'h9999; #1;
    chk("t6_memaddr", MemAddr, 16'h0000);
    chk("t6_memread", MemRead, 0);
    chk("t6_datain", DataIn, 16'h0000);
    chk("t6_dwait", DataWaitreq, 0);
    tick();
    quiet();
    ReadData = 1; DataAddr = 16'h0900;
    tick(); #1;
    chk("t6_next_memaddr", MemAddr, 16'h0900);
    chk("t6_next_memread", MemRead, 1);
    tick();
    MemRdvalid = 1; MemRdata = 16'h4242; #1;
    chk("t6_next_datain", DataIn, 16'h4242);
    chk("t6_next_dwait", DataWaitreq, 0);
    tick();
    quiet();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
